// File: rtl/otter_csr_pkg.sv
// Shared definitions for the OTTER machine-mode CSR file.
package otter_csr_pkg;

  localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_ADDR_MIE      = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_ADDR_MIP      = 12'h344;
  localparam logic [11:0] CSR_ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned IRQ_CAUSE_BASE = 16;
  localparam int unsigned IRQ_ID_W       = 4;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_t;

endpackage

// File: rtl/otter_csr_file_csr_irq_arbiter.sv
// Interrupt edge capture, mip bookkeeping and fixed-priority (lowest index) selection.
module csr_irq_arbiter
  import otter_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  mie_bits,
  input  logic [NUM_IRQ-1:0]  clr_mask,
  output logic [NUM_IRQ-1:0]  mip,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic                any_pending
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mip_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic               armed_q;

  // First cycle after reset only primes the history, so a line already high is not seen as an edge
  assign rise = armed_q ? (irq_in & ~irq_q) : '0;

  // Edge history and pending bits; a new edge overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q   <= '0;
      mip_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      armed_q <= 1'b1;
      mip_q   <= (mip_q & ~clr_mask) | rise;
    end
  end

  assign mip         = mip_q;
  assign active      = mip_q & mie_bits;
  assign any_pending = |active;

  // Lowest enabled pending index wins
  always_comb begin
    irq_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) irq_id = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/otter_csr_file.sv
// Machine-mode CSR file: status/enable/trap registers, interrupt arbitration, cycle/instret counters.
module otter_csr_file
  import otter_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned CNT_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wd,
  input  logic [31:0]        pc,
  input  logic               mret_exec,
  input  logic               int_ack,
  input  logic               instr_retired,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [31:0]        csr_rd,
  output logic               csr_illegal,
  output logic               int_req,
  output logic [31:0]        trap_pc,
  output logic [31:0]        csr_mepc,
  output logic               csr_mstatus_mie
);

  logic                mstatus_mie_q;
  logic                mstatus_mpie_q;
  logic [NUM_IRQ-1:0]  mie_q;
  logic [31:0]         mtvec_q;
  logic [31:0]         mepc_q;
  logic [31:0]         mcause_q;
  logic [63:0]         mcycle_q;
  logic [63:0]         minstret_q;
  logic [NUM_IRQ-1:0]  mip;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                any_pending;
  logic                mapped;
  logic [31:0]         wr_val;
  logic                wr_en;
  logic                ack_ok;
  logic [NUM_IRQ-1:0]  clr_mask;
  csr_op_t             op;

  assign op = csr_op_t'(csr_op);

  csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_irq_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_in      (irq_in),
    .mie_bits    (mie_q),
    .clr_mask    (clr_mask),
    .mip         (mip),
    .irq_id      (irq_id),
    .any_pending (any_pending)
  );

  // Read mux; also flags whether the address is implemented
  always_comb begin
    csr_rd = '0;
    mapped = 1'b1;
    case (csr_addr)
      CSR_ADDR_MSTATUS: begin
        csr_rd[MSTATUS_MIE]  = mstatus_mie_q;
        csr_rd[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_ADDR_MIE:       csr_rd = 32'(mie_q) << IRQ_CAUSE_BASE;
      CSR_ADDR_MTVEC:     csr_rd = mtvec_q;
      CSR_ADDR_MEPC:      csr_rd = mepc_q;
      CSR_ADDR_MCAUSE:    csr_rd = mcause_q;
      CSR_ADDR_MIP:       csr_rd = 32'(mip) << IRQ_CAUSE_BASE;
      CSR_ADDR_MCYCLE:    csr_rd = mcycle_q[31:0];
      CSR_ADDR_MCYCLEH:   csr_rd = mcycle_q[63:32];
      CSR_ADDR_MINSTRET:  csr_rd = minstret_q[31:0];
      CSR_ADDR_MINSTRETH: csr_rd = minstret_q[63:32];
      default:            mapped = 1'b0;
    endcase
  end

  // Read-modify-write value and the gating that decides whether a CSR write lands
  always_comb begin
    wr_val = csr_rd;
    case (op)
      CSR_WRITE: wr_val = csr_wd;
      CSR_SET:   wr_val = csr_rd | csr_wd;
      CSR_CLEAR: wr_val = csr_rd & ~csr_wd;
      default:   wr_val = csr_rd;
    endcase
    wr_en = mapped && ((op == CSR_WRITE) || ((op != CSR_NONE) && (csr_wd != 32'd0)))
            && !ack_ok && !mret_exec;
  end

  assign csr_illegal = (op != CSR_NONE) && !mapped;
  assign int_req     = mstatus_mie_q && any_pending;
  assign ack_ok      = int_ack && int_req;

  // Pending bits dropped by the taken trap or by a csrrc on mip
  always_comb begin
    clr_mask = '0;
    if (ack_ok) clr_mask = NUM_IRQ'(1) << irq_id;
    else if (wr_en && (csr_addr == CSR_ADDR_MIP) && (op == CSR_CLEAR))
      clr_mask = csr_wd[IRQ_CAUSE_BASE +: NUM_IRQ];
  end

  // Vectored mode offsets the base by 4 * cause code
  always_comb begin
    trap_pc = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == MTVEC_MODE_VECTORED)
      trap_pc = {mtvec_q[31:2], 2'b00} + ((32'(IRQ_CAUSE_BASE) + 32'(irq_id)) << 2);
  end

  assign csr_mepc        = mepc_q;
  assign csr_mstatus_mie = mstatus_mie_q;

  // Trap entry beats mret, which beats a software write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else if (ack_ok) begin
      mepc_q         <= pc & ~32'd3;
      mcause_q       <= 32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + 32'(irq_id));
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_exec) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_ADDR_MSTATUS: begin
          mstatus_mie_q  <= wr_val[MSTATUS_MIE];
          mstatus_mpie_q <= wr_val[MSTATUS_MPIE];
        end
        CSR_ADDR_MIE:    mie_q    <= wr_val[IRQ_CAUSE_BASE +: NUM_IRQ];
        CSR_ADDR_MTVEC:  mtvec_q  <= wr_val & ~32'd2;
        CSR_ADDR_MEPC:   mepc_q   <= wr_val & ~32'd3;
        CSR_ADDR_MCAUSE: mcause_q <= wr_val;
        default: ;
      endcase
    end
  end

  if (CNT_EN != 0) begin : g_cnt
    logic [63:0] mcycle_nxt;
    logic [63:0] minstret_nxt;

    // A write to either half replaces it and skips that counter's increment
    always_comb begin
      mcycle_nxt   = mcycle_q + 64'd1;
      minstret_nxt = instr_retired ? (minstret_q + 64'd1) : minstret_q;
      if (wr_en) begin
        case (csr_addr)
          CSR_ADDR_MCYCLE:    mcycle_nxt   = {mcycle_q[63:32], wr_val};
          CSR_ADDR_MCYCLEH:   mcycle_nxt   = {wr_val, mcycle_q[31:0]};
          CSR_ADDR_MINSTRET:  minstret_nxt = {minstret_q[63:32], wr_val};
          CSR_ADDR_MINSTRETH: minstret_nxt = {wr_val, minstret_q[31:0]};
          default: ;
        endcase
      end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mcycle_q   <= '0;
        minstret_q <= '0;
      end else begin
        mcycle_q   <= mcycle_nxt;
        minstret_q <= minstret_nxt;
      end
    end
  end else begin : g_no_cnt
    assign mcycle_q   = '0;
    assign minstret_q = '0;
  end

endmodule

// File: tb/tb_otter_csr_file.sv
// Directed self-checking bench for otter_csr_file.
module tb_otter_csr_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wd;
  logic [31:0] pc;
  logic        mret_exec;
  logic        int_ack;
  logic        instr_retired;
  logic [3:0]  irq_in;
  logic [31:0] csr_rd;
  logic        csr_illegal;
  logic        int_req;
  logic [31:0] trap_pc;
  logic [31:0] csr_mepc;
  logic        csr_mstatus_mie;

  int checks   = 0;
  int failures = 0;

  otter_csr_file #(.NUM_IRQ(4), .CNT_EN(1)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .csr_addr        (csr_addr),
    .csr_op          (csr_op),
    .csr_wd          (csr_wd),
    .pc              (pc),
    .mret_exec       (mret_exec),
    .int_ack         (int_ack),
    .instr_retired   (instr_retired),
    .irq_in          (irq_in),
    .csr_rd          (csr_rd),
    .csr_illegal     (csr_illegal),
    .int_req         (int_req),
    .trap_pc         (trap_pc),
    .csr_mepc        (csr_mepc),
    .csr_mstatus_mie (csr_mstatus_mie)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_addr = a;
    csr_op   = 2'b00;
    #1;
    check(tag, csr_rd, exp);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op   = op;
    csr_addr = a;
    csr_wd   = d;
    tick();
    csr_op   = 2'b00;
    csr_wd   = 32'd0;
  endtask

  initial begin
    reset_n = 1'b0; csr_addr = 12'h000; csr_op = 2'b00; csr_wd = 32'd0; pc = 32'd0;
    mret_exec = 1'b0; int_ack = 1'b0; instr_retired = 1'b0; irq_in = 4'b0000;
    #10;
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_trap_pc", trap_pc, 32'd0);
    check("rst_mepc", csr_mepc, 32'd0);
    rd(12'h305, 32'd0, "rst_mtvec");
    #10 reset_n = 1'b1;
    tick();

    // Test 1: basic writes and reads
    wr(2'b01, 12'h305, 32'h0000_1001);
    wr(2'b01, 12'h304, 32'h0001_0000);
    wr(2'b01, 12'h300, 32'h0000_0008);
    rd(12'h305, 32'h0000_1001, "t1_mtvec");
    rd(12'h300, 32'h0000_0008, "t1_mstatus");
    rd(12'h304, 32'h0001_0000, "t1_mie");
    csr_op = 2'b01; csr_addr = 12'h305; csr_wd = 32'h0000_1001; #1;
    check("t1_illegal", 32'(csr_illegal), 32'd0);
    csr_op = 2'b00;
    check("t1_mstatus_mie", 32'(csr_mstatus_mie), 32'd1);

    // Test 2: single interrupt, vectored target, trap entry
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    rd(12'h344, 32'h0001_0000, "t2_mip");
    check("t2_int_req", 32'(int_req), 32'd1);
    check("t2_trap_pc", trap_pc, 32'h0000_1040);
    int_ack = 1'b1; pc = 32'h0000_0206;
    tick();
    int_ack = 1'b0;
    rd(12'h341, 32'h0000_0204, "t2_mepc");
    check("t2_csr_mepc", csr_mepc, 32'h0000_0204);
    rd(12'h342, 32'h8000_0010, "t2_mcause");
    rd(12'h300, 32'h0000_0080, "t2_mstatus");
    rd(12'h344, 32'h0000_0000, "t2_mip_clr");
    check("t2_int_req_clr", 32'(int_req), 32'd0);
    // ack without a request is ignored
    int_ack = 1'b1; pc = 32'h0000_0500;
    tick();
    int_ack = 1'b0;
    check("t2_ack_ignored", csr_mepc, 32'h0000_0204);

    // Test 3: simultaneous edges, lowest index wins
    wr(2'b01, 12'h304, 32'h0006_0000);
    wr(2'b01, 12'h300, 32'h0000_0008);
    irq_in = 4'b0110;
    tick();
    rd(12'h344, 32'h0006_0000, "t3_mip");
    check("t3_trap_pc", trap_pc, 32'h0000_1044);
    int_ack = 1'b1; pc = 32'h0000_0300;
    tick();
    int_ack = 1'b0;
    rd(12'h342, 32'h8000_0011, "t3_mcause");
    rd(12'h344, 32'h0004_0000, "t3_mip_left");
    rd(12'h300, 32'h0000_0080, "t3_mstatus");
    // clear pending while the line stays high; no re-trigger from the level
    irq_in = 4'b0100;
    wr(2'b11, 12'h344, 32'h0004_0000);
    rd(12'h344, 32'h0000_0000, "t3_mip_cleared");
    tick();
    rd(12'h344, 32'h0000_0000, "t3_level_no_reset");
    irq_in = 4'b0000;
    tick();
    // edge and clear of the same bit in one cycle: set wins
    irq_in = 4'b0001;
    wr(2'b11, 12'h344, 32'h0001_0000);
    rd(12'h344, 32'h0001_0000, "t3_set_wins");
    wr(2'b11, 12'h344, 32'h0001_0000);
    rd(12'h344, 32'h0000_0000, "t3_clear_after");
    irq_in = 4'b0000;

    // Test 4: mret beats a same-cycle mstatus write
    mret_exec = 1'b1;
    wr(2'b01, 12'h300, 32'h0000_0000);
    mret_exec = 1'b0;
    rd(12'h300, 32'h0000_0088, "t4_mstatus");
    check("t4_mepc_kept", csr_mepc, 32'h0000_0300);

    // Test 5: counters and carry
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'h0000_0000);
    rd(12'hB00, 32'hFFFF_FFFF, "t5_mcycle_held");
    tick();
    rd(12'hB00, 32'h0000_0000, "t5_mcycle_lo");
    rd(12'hB80, 32'h0000_0001, "t5_mcycle_hi");
    rd(12'hB02, 32'h0000_0000, "t5_minstret_lo");
    rd(12'hB82, 32'h0000_0000, "t5_minstret_hi");
    instr_retired = 1'b1;
    tick(); tick(); tick();
    instr_retired = 1'b0;
    rd(12'hB02, 32'h0000_0003, "t5_minstret_3");
    wr(2'b01, 12'hB02, 32'hFFFF_FFFF);
    instr_retired = 1'b1;
    wr(2'b01, 12'hB82, 32'hFFFF_FFFF);
    instr_retired = 1'b0;
    rd(12'hB02, 32'hFFFF_FFFF, "t5_minstret_sup_lo");
    rd(12'hB82, 32'hFFFF_FFFF, "t5_minstret_sup_hi");
    instr_retired = 1'b1;
    tick();
    instr_retired = 1'b0;
    rd(12'hB02, 32'h0000_0000, "t5_wrap_lo");
    rd(12'hB82, 32'h0000_0000, "t5_wrap_hi");

    // Test 6: unmapped access, then reset in the middle of a trap ack
    csr_op = 2'b10; csr_addr = 12'h7C0; csr_wd = 32'h0000_0001; #1;
    check("t6_illegal", 32'(csr_illegal), 32'd1);
    check("t6_rd_zero", csr_rd, 32'd0);
    tick();
    csr_op = 2'b00; #1;
    check("t6_illegal_none", 32'(csr_illegal), 32'd0);
    rd(12'h305, 32'h0000_1001, "t6_mtvec_kept");
    rd(12'h300, 32'h0000_0088, "t6_mstatus_kept");
    wr(2'b01, 12'h304, 32'h0001_0000);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0010;
    check("t6_int_req", 32'(int_req), 32'd1);
    int_ack = 1'b1; pc = 32'h0000_0400;
    csr_op = 2'b01; csr_addr = 12'h7C0;
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_illegal", 32'(csr_illegal), 32'd1);
    check("t6_rst_int_req", 32'(int_req), 32'd0);
    check("t6_rst_trap_pc", trap_pc, 32'd0);
    check("t6_rst_mepc", csr_mepc, 32'd0);
    check("t6_rst_mie_bit", 32'(csr_mstatus_mie), 32'd0);
    rd(12'h305, 32'd0, "t6_rst_mtvec");
    rd(12'h342, 32'd0, "t6_rst_mcause");
    rd(12'hB00, 32'd0, "t6_rst_mcycle");
    int_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    // irq_in[1] stays high across reset release and must not be latched
    wr(2'b01, 12'h304, 32'h0002_0000);
    wr(2'b01, 12'h300, 32'h0000_0008);
    tick();
    rd(12'h344, 32'h0000_0000, "t6_no_redetect");
    check("t6_no_int_req", 32'(int_req), 32'd0);
    irq_in = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_csr_file.md
Name: otter_csr_file

Overview:
Parametrised machine-mode CSR file for the OTTER core.
- Generalises the current three-register CSR block with: csrrw/csrrs/csrrc operations, mie/mip/mcause, NUM_IRQ edge-latched interrupt lines with fixed priority, vectored mtvec, and 64-bit mcycle/minstret counters.
- Sits beside the decoder and the PC mux; supplies trap target, mepc and the interrupt request to the control FSM.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16); line i maps to mcause code 16+i.
- CNT_EN, 1, when 0, counter CSRs read 0 and their increment logic is removed.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address from instruction[31:20]
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_wd  in  32  rs1 value or zero-extended immediate
- pc  in  32  PC of the instruction being interrupted
- mret_exec  in  1  mret retiring this cycle
- int_ack  in  1  control FSM takes the trap this cycle
- instr_retired  in  1  one instruction retired this cycle
- irq_in  in  NUM_IRQ  interrupt lines, synchronous to clk, level input
- csr_rd  out  32  old value of the addressed CSR (combinational)
- csr_illegal  out  1  csr_op!=00 and csr_addr unmapped (combinational)
- int_req  out  1  interrupt pending and enabled
- trap_pc  out  32  trap target address
- csr_mepc  out  32  mepc, for mret
- csr_mstatus_mie  out  1  mstatus[3]

Behaviour:
- Address map:
  - mstatus 0x300 (only bits 3 MIE and 7 MPIE exist; other bits read 0, writes ignored)
  - mie 0x304 (bits NUM_IRQ+15:16)
  - mtvec 0x305 (bit 1 reads 0)
  - mepc 0x341 (bits 1:0 read 0)
  - mcause 0x342
  - mip 0x344 (same bits as mie; only clear op has effect)
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82
- Reset (async, reset_n=0): all CSRs and counters = 0, irq edge history = 0. Outputs during reset: csr_rd 0 unless addressed CSR reads nonzero (none at reset), int_req 0, trap_pc 0, csr_mepc 0, csr_mstatus_mie 0, csr_illegal per inputs.
- Write value: op 01 -> wd; 10 -> old|wd; 11 -> old&~wd. Set/clear with wd=0 perform no write. Update takes effect on the next clk edge; csr_rd always shows the pre-write value.
- Unmapped address: read 0, write dropped, csr_illegal=1 while op!=00.
- irq: a rising edge on irq_in[i] (vs. the previous-cycle sample) sets mip[16+i] next cycle.
  - A set and a clear of the same bit in one cycle (clear op or trap ack) -> set wins.
  - A level held high does not re-set mip.
- int_req = mstatus.MIE & |(mip & mie), from registered state only (no same-cycle bypass).
- Winner id = lowest index i with mip&mie bit set.
- trap_pc:
  - mtvec[1:0]==01: {mtvec[31:2],2'b00} + 4*(16+id)
  - otherwise {mtvec[31:2],2'b00}.
- int_ack is honoured only when int_req=1. Honoured ack, on the next edge:
  - mepc<=pc & ~3
  - mcause<=32'h8000_0000 | (16+id)
  - MPIE<=MIE, MIE<=0
  - mip[16+id]<=0
- mret_exec: MIE<=MPIE, MPIE<=1.
- Priority in one cycle: honoured int_ack > mret_exec > CSR write. The lower-priority action is dropped entirely, except counter increments, which always occur.
- Counters (64-bit):
  - mcycle +1 every cycle; minstret +1 when instr_retired.
  - A CSR write to either 32-bit half replaces that half and suppresses that counter's increment for the cycle.
  - Low-half increment from all-ones carries into the high half; 64-bit all-ones wraps to 0.
- Reset asserted mid-operation clears everything immediately; a pending edge whose source is still high after reset release is not re-detected.

Decomposition:
- Package otter_csr_pkg: CSR address localparams, csr_op_t enum (CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR), MSTATUS_MIE=3, MSTATUS_MPIE=7, IRQ_CAUSE_BASE=16, MTVEC_MODE_VECTORED=2'b01.
- Sub-module csr_irq_arbiter: edge detect, mip set/clear, priority encode; outputs pending vector, id, any_pending.

Test Plan:
1. Reset, write mtvec=0x0000_1001 (op 01), mie=0x0001_0000, mstatus=0x8 -> reads mtvec=0x0000_1001, mstatus=0x8; csr_illegal 0.
2. Pulse irq_in[0] -> mip=0x0001_0000 next cycle, int_req=1, trap_pc=0x0000_1040. Ack with pc=0x0000_0206 -> mepc=0x0000_0204, mcause=0x8000_0010, mstatus=0x80, mip=0, int_req=0.
3. irq_in[2] and irq_in[1] edges same cycle with mie=0x0006_0000 -> id=1, mcause=0x8000_0011 after ack; mip[18] remains set.
4. mret_exec and CSR write to mstatus same cycle -> mstatus=0x88 (mret wins), write lost.
5. Write mcycle=0xFFFF_FFFF, mcycleh=0 -> after 2 cycles mcycle=0x0000_0000, mcycleh=1. minstret unchanged while instr_retired=0.
6. Set op to 0x7C0 -> csr_illegal=1, csr_rd=0, no state change. Assert reset_n low mid-trap-ack -> all CSRs 0 without a clock edge.
